// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises one read or write frame per
// accepted command, generating MDC from clk_200m by a HALF_DIV divider.
module mdio_master #(
  parameter int HALF_DIV     = 40,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_200m,
  input  logic        rst_200m,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        mdio_in
);

  localparam int DIV_W = $clog2(2 * HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF_DIV - 1);
  localparam logic [4:0] PRE_LAST = (PREAMBLE_LEN > 0) ? 5'(PREAMBLE_LEN - 1) : 5'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_CMD,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  state_t           state, state_n, follow;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [4:0]       bit_cnt, bit_n, last_idx;
  logic             bit_end, in_frame_n;
  logic             is_write, ta_err, mdc_q;
  logic [31:0]      tx_shift;
  logic [15:0]      rx_shift;

  assign bit_end   = (div_cnt == DIV_LAST);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign mdc       = mdc_q;

  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    bit_n    = bit_cnt;
    last_idx = 5'd15;
    follow   = S_DONE;
    case (state)
      S_PRE:   begin last_idx = PRE_LAST; follow = S_CMD;  end
      S_CMD:   begin last_idx = 5'd13;    follow = S_TA;   end
      S_TA:    begin last_idx = 5'd1;     follow = S_DATA; end
      default: begin last_idx = 5'd15;    follow = S_DONE; end
    endcase

    case (state)
      S_IDLE: begin
        div_n = '0;
        bit_n = '0;
        if (cmd_valid) state_n = (PREAMBLE_LEN == 0) ? S_CMD : S_PRE;
      end
      S_PRE, S_CMD, S_TA, S_DATA: begin
        if (bit_end) begin
          div_n = '0;
          if (bit_cnt == last_idx) begin
            bit_n   = '0;
            state_n = follow;
          end else begin
            bit_n = bit_cnt + 5'd1;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        div_n   = '0;
        bit_n   = '0;
      end
    endcase

    in_frame_n = (state_n == S_PRE) || (state_n == S_CMD) ||
                 (state_n == S_TA)  || (state_n == S_DATA);
  end

  // Pad drive: on reads the master lets go of MDIO from the first TA bit onward
  always_comb begin
    mdio_out = 1'b1;
    mdio_oen = 1'b1;
    case (state)
      S_PRE: mdio_oen = 1'b0;
      S_CMD: begin
        mdio_out = tx_shift[31];
        mdio_oen = 1'b0;
      end
      S_TA, S_DATA: begin
        if (is_write) begin
          mdio_out = tx_shift[31];
          mdio_oen = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_200m) begin
    if (rst_200m) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      mdc_q     <= 1'b0;
      is_write  <= 1'b0;
      ta_err    <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      // MDC is registered from the next-state view so it never glitches
      mdc_q   <= in_frame_n && (div_n >= DIV_RISE);

      if (state == S_IDLE && cmd_valid) begin
        is_write <= cmd_write;
        tx_shift <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr,
                     cmd_reg_addr, 2'b10, cmd_wdata};
      end else if ((state == S_CMD || state == S_TA || state == S_DATA) && bit_end) begin
        tx_shift <= {tx_shift[30:0], 1'b0};
      end

      if (!is_write && div_cnt == DIV_RISE) begin
        if (state == S_TA && bit_cnt == 5'd1) ta_err <= mdio_in;
        else if (state == S_DATA) rx_shift <= {rx_shift[14:0], mdio_in};
      end

      if (state == S_DATA && state_n == S_DONE) begin
        rsp_err <= !is_write && ta_err;
        if (!is_write) rsp_rdata <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Randomised self-checking bench for mdio_master: a bit-queue frame model plus
// a simple PHY responder; a second instance covers the no-preamble case.
module tb_mdio_master;

  localparam int H  = 2;
  localparam int P  = 32;
  localparam int N  = P + 32;
  localparam int H2 = 3;
  localparam int P2 = 0;
  localparam int N2 = P2 + 32;

  typedef struct packed {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err, busy, mdc, mdio_out, mdio_oen, mdio_in;
  logic [15:0] rsp_rdata;

  logic        cmd_valid2, cmd_ready2, cmd_write2;
  logic [4:0]  cmd_phy_addr2, cmd_reg_addr2;
  logic [15:0] cmd_wdata2;
  logic        rsp_valid2, rsp_err2, busy2, mdc2, mdio_out2, mdio_oen2;
  logic [15:0] rsp_rdata2;

  mdio_master #(.HALF_DIV(H), .PREAMBLE_LEN(P)) dut (
    .clk_200m(clk), .rst_200m(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_out(mdio_out), .mdio_oen(mdio_oen), .mdio_in(mdio_in)
  );

  mdio_master #(.HALF_DIV(H2), .PREAMBLE_LEN(P2)) dut2 (
    .clk_200m(clk), .rst_200m(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write2),
    .cmd_phy_addr(cmd_phy_addr2), .cmd_reg_addr(cmd_reg_addr2), .cmd_wdata(cmd_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2),
    .mdc(mdc2), .mdio_out(mdio_out2), .mdio_oen(mdio_oen2), .mdio_in(1'b1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int rsp_seen = 0, rsp_expected = 0, wide_pulses = 0, last_rsp_cyc = 0;
  logic prev_rsp = 1'b0;
  logic [15:0] model_rdata = 16'h0000;
  bit frame_q[$];

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_seen++;
    if (rsp_valid === 1'b1 && prev_rsp === 1'b1) wide_pulses++;
    prev_rsp = rsp_valid;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_field(input logic [15:0] v, input int width);
    for (int i = width - 1; i >= 0; i--) frame_q.push_back(v[i]);
  endfunction

  // Expected bit stream as seen at each MDC rise: preamble, ST, OP, PHYAD, REGAD, TA, DATA
  function automatic void build_frame(input cmd_t c, input int pre);
    frame_q.delete();
    for (int i = 0; i < pre; i++) frame_q.push_back(1'b1);
    push_field(16'b01, 2);
    push_field(c.wr ? 16'b01 : 16'b10, 2);
    push_field({11'd0, c.phy}, 5);
    push_field({11'd0, c.rg}, 5);
    push_field(16'b10, 2);
    push_field(c.wd, 16);
  endfunction

  // PHY responder: mode 0 = good PHY, 1 = absent (line pulled high), 2 = bad TA
  function automatic logic phy_bit(input int k, input int mode, input logic [15:0] d);
    if (k == P + 14) return 1'b1;
    if (k == P + 15) return (mode == 0) ? 1'b0 : 1'b1;
    if (k >= P + 16 && k < P + 32) return (mode == 1) ? 1'b1 : d[15 - (k - P - 16)];
    return 1'b1;
  endfunction

  task automatic applyStimulus(input cmd_t cmd, input int mode, input logic [15:0] phy_data,
                               input bit b2b);
    int a, now, k, rsp_cyc, rises, bad_time, bad_bit, bad_oen, bad_busy;
    logic prev_mdc, exp_oen, exp_out, got_err, exp_err;
    logic [15:0] got_rdata, exp_rdata;
    bit accepted;
    build_frame(cmd, P);
    cmd_write    = cmd.wr;
    cmd_phy_addr = cmd.phy;
    cmd_reg_addr = cmd.rg;
    cmd_wdata    = cmd.wd;
    cmd_valid    = 1'b1;
    accepted = 0;
    a = 0;
    for (int w = 0; w < 20; w++) begin
      if (cmd_ready === 1'b1) begin
        accepted = 1;
        a = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("accept", 32'(accepted), 32'd1);
    if (!accepted) begin
      cmd_valid = 1'b0;
      return;
    end
    if (b2b) checkOutput("b2b_accept", a, last_rsp_cyc + 1);
    rsp_cyc = -1; rises = 0; bad_time = 0; bad_bit = 0; bad_oen = 0; bad_busy = 0;
    got_rdata = '0; got_err = 1'b0;
    prev_mdc = mdc;
    if (mdc !== 1'b0) bad_time++;
    for (int t = 0; t < 2 * H * N + 20; t++) begin
      @(negedge clk);
      now = cyc;
      k = (now - a - 1) / (2 * H);
      if (rsp_valid === 1'b1) begin
        rsp_cyc = now;
        got_rdata = rsp_rdata;
        got_err = rsp_err;
        if (mdc !== 1'b0) bad_time++;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
      if (mdc === 1'b1 && prev_mdc === 1'b0) begin
        if (rises >= N) bad_time++;
        else begin
          if (now != a + 1 + H + 2 * H * rises) bad_time++;
          exp_oen = !cmd.wr && (rises >= P + 14);
          exp_out = exp_oen ? 1'b1 : frame_q[rises];
          if (mdio_oen !== exp_oen) bad_oen++;
          if (mdio_out !== exp_out) bad_bit++;
        end
        rises++;
      end
      prev_mdc = mdc;
      mdio_in      = cmd.wr ? 1'($urandom) : phy_bit(k, mode, phy_data);
      cmd_write    = 1'($urandom);
      cmd_phy_addr = 5'($urandom);
      cmd_reg_addr = 5'($urandom);
      cmd_wdata    = 16'($urandom);
    end
    cmd_valid = 1'b0;
    mdio_in   = 1'b1;
    checkOutput("latency", rsp_cyc - a, 1 + 2 * H * N);
    checkOutput("rise_count", rises, N);
    checkOutput("rise_timing", bad_time, 0);
    checkOutput("mdio_bits", bad_bit, 0);
    checkOutput("mdio_oen", bad_oen, 0);
    checkOutput("busy", bad_busy, 0);
    if (rsp_cyc >= 0) begin
      if (cmd.wr) begin
        exp_rdata = model_rdata;
        exp_err   = 1'b0;
      end else begin
        exp_rdata = (mode == 1) ? 16'hFFFF : phy_data;
        exp_err   = (mode != 0);
        model_rdata = exp_rdata;
      end
      checkOutput("rsp_rdata", got_rdata, exp_rdata);
      checkOutput("rsp_err", got_err, exp_err);
      rsp_expected++;
      last_rsp_cyc = rsp_cyc;
    end
  endtask

  initial begin
    int a, now, rises, bad_bit, rsp_cyc, gap, mode;
    bit accepted;
    cmd_t c;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_wdata = '0;
    cmd_valid2 = 1'b0; cmd_write2 = 1'b0; cmd_phy_addr2 = '0; cmd_reg_addr2 = '0; cmd_wdata2 = '0;
    mdio_in = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", cmd_ready, 1);
    checkOutput("reset_mdc", mdc, 0);
    checkOutput("reset_mdio_out", mdio_out, 1);
    checkOutput("reset_oen", mdio_oen, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_rdata", rsp_rdata, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus('{wr: 1'b1, phy: 5'h03, rg: 5'h1F, wd: 16'hA5C3}, 0, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus('{wr: 1'b0, phy: 5'h01, rg: 5'h02, wd: 16'h0000}, 0, 16'h1234, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus('{wr: 1'b0, phy: 5'h07, rg: 5'h11, wd: 16'h0000}, 1, 16'h0000, 1'b0);
    applyStimulus('{wr: 1'b1, phy: 5'h0A, rg: 5'h04, wd: 16'h3C5A}, 0, 16'h0000, 1'b1);

    for (int i = 0; i < 6; i++) begin
      c.wr  = 1'($urandom);
      c.phy = 5'($urandom);
      c.rg  = 5'($urandom);
      c.wd  = 16'($urandom);
      gap   = $urandom_range(0, 3);
      mode  = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      applyStimulus(c, mode, 16'($urandom), gap == 0);
    end

    // Abort a write in mid-frame with reset
    @(negedge clk);
    cmd_write = 1'b1; cmd_phy_addr = 5'h12; cmd_reg_addr = 5'h05; cmd_wdata = 16'hBEEF;
    cmd_valid = 1'b1;
    accepted = 0;
    a = 0;
    for (int w = 0; w < 20; w++) begin
      if (cmd_ready === 1'b1) begin
        accepted = 1;
        a = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("abort_accept", 32'(accepted), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int w = 0; w < 200 && cyc < a + 100; w++) @(negedge clk);
    checkOutput("abort_driving", mdio_oen, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_mdc", mdc, 0);
    checkOutput("abort_oen", mdio_oen, 1);
    checkOutput("abort_mdio_out", mdio_out, 1);
    checkOutput("abort_ready", cmd_ready, 1);
    checkOutput("abort_rdata", rsp_rdata, 16'h0000);
    rst = 1'b0;
    model_rdata = 16'h0000;
    repeat (300) @(negedge clk);
    checkOutput("abort_no_rsp", rsp_seen, rsp_expected);

    applyStimulus('{wr: 1'b0, phy: 5'h1C, rg: 5'h09, wd: 16'h0000}, 0, 16'hC0DE, 1'b0);

    // No-preamble instance with a wider divider
    c = '{wr: 1'b1, phy: 5'h15, rg: 5'h0B, wd: 16'h6E91};
    build_frame(c, P2);
    @(negedge clk);
    cmd_write2 = c.wr; cmd_phy_addr2 = c.phy; cmd_reg_addr2 = c.rg; cmd_wdata2 = c.wd;
    cmd_valid2 = 1'b1;
    accepted = 0;
    a = 0;
    for (int w = 0; w < 20; w++) begin
      if (cmd_ready2 === 1'b1) begin
        accepted = 1;
        a = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("p0_accept", 32'(accepted), 32'd1);
    rises = 0; bad_bit = 0; rsp_cyc = -1;
    for (int t = 0; t < 2 * H2 * N2 + 20; t++) begin
      @(negedge clk);
      cmd_valid2 = 1'b0;
      now = cyc;
      if (rsp_valid2 === 1'b1) begin
        rsp_cyc = now;
        break;
      end
      if (mdc2 === 1'b1 && now == a + 1 + H2 + 2 * H2 * rises) begin
        if (rises == 0) checkOutput("p0_first_bit", mdio_out2, 0);
        if (rises < N2 && mdio_out2 !== frame_q[rises]) bad_bit++;
        rises++;
      end
    end
    checkOutput("p0_latency", rsp_cyc - a, 1 + 2 * H2 * N2);
    checkOutput("p0_rise_count", rises, N2);
    checkOutput("p0_bits", bad_bit, 0);

    checkOutput("rsp_pulse_count", rsp_seen, rsp_expected);
    checkOutput("rsp_pulse_width", wide_pulses, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
